// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator: default 640x480@60 timing,
// register addresses and CTRL/STATUS bit positions.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_FRAME  = 2'd2;
    localparam logic [1:0] ADDR_POS    = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_HPOL   = 1;
    localparam int CTRL_VPOL   = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STATUS_FRAME_IRQ = 0;
    localparam int STATUS_VBLANK    = 1;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Avalon-MM slave bus of the VGA timing generator.
interface vga_timing_gen_if;
    // A write is accepted on every clk edge with chipselect && !write_n (no wait
    // states); readdata always shows the word at the previous cycle's address.
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap flag plus sync and active decode.
// Used for both the horizontal (pixels) and vertical (lines) axis.
module vga_axis_counter #(
    parameter int WIDTH  = 11,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o,
    output logic             sync_o,
    output logic             active_o
);
    localparam int TOTAL = vga_pkg::axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] SYNC_FIRST = WIDTH'(ACTIVE + FP);
    localparam logic [WIDTH-1:0] SYNC_LAST  = WIDTH'(ACTIVE + FP + SYNC - 1);
    localparam logic [WIDTH-1:0] ACTIVE_END = WIDTH'(ACTIVE);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Disabled axis is parked at 0 so enabling always starts a fresh frame.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign last_o   = (cnt_q == LAST);
    assign sync_o   = (cnt_q >= SYNC_FIRST) && (cnt_q <= SYNC_LAST);
    assign active_o = (cnt_q < ACTIVE_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/display-enable generator with an Avalon-MM register block
// (control, sticky frame interrupt, frame counter, raster position).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    vga_timing_gen_if.slave     bus,
    output logic                irq,
    output logic                hs,
    output logic                vs,
    output logic                de,
    output logic [H_CNT_W-1:0]  pix_x,
    output logic [V_CNT_W-1:0]  pix_y
);
    logic [3:0]         ctrl_q, ctrl_d;
    logic               frame_irq_q, frame_irq_d;
    logic [31:0]        frame_cnt_q, frame_cnt_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [H_CNT_W-1:0] pix_x_q, pix_x_d;
    logic [V_CNT_W-1:0] pix_y_q, pix_y_d;

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic h_last, h_sync, h_active;
    logic v_last, v_sync, v_active;
    logic en, wr_en, frame_end;
    logic unused_wdata;

    assign en           = ctrl_q[CTRL_EN];
    assign wr_en        = bus.chipselect && !bus.write_n;
    assign frame_end    = en && h_last && v_last;
    assign unused_wdata = ^bus.writedata[31:4];

    vga_axis_counter #(
        .WIDTH(H_CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk(clk), .reset(reset), .en_i(en), .step_i(1'b1),
        .cnt_o(h_cnt), .last_o(h_last), .sync_o(h_sync), .active_o(h_active)
    );

    vga_axis_counter #(
        .WIDTH(V_CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk(clk), .reset(reset), .en_i(en), .step_i(h_last),
        .cnt_o(v_cnt), .last_o(v_last), .sync_o(v_sync), .active_o(v_active)
    );

    always_comb begin
        ctrl_d      = ctrl_q;
        frame_irq_d = frame_irq_q;
        frame_cnt_d = frame_cnt_q;
        if (wr_en && bus.address == ADDR_CTRL) begin
            ctrl_d = bus.writedata[3:0];
        end
        if (wr_en && bus.address == ADDR_STATUS && bus.writedata[STATUS_FRAME_IRQ]) begin
            frame_irq_d = 1'b0;
        end
        // A frame end in the same cycle as a clear must leave the flag set.
        if (frame_end) begin
            frame_irq_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 32'd1;
        end

        de_d    = en && h_active && v_active;
        hs_d    = (en && h_sync) ? ctrl_q[CTRL_HPOL] : !ctrl_q[CTRL_HPOL];
        vs_d    = (en && v_sync) ? ctrl_q[CTRL_VPOL] : !ctrl_q[CTRL_VPOL];
        pix_x_d = de_d ? h_cnt : '0;
        pix_y_d = de_d ? v_cnt : '0;

        case (bus.address)
            ADDR_CTRL:   readdata_d = {28'd0, ctrl_q};
            ADDR_STATUS: readdata_d = {30'd0, !v_active, frame_irq_q};
            ADDR_FRAME:  readdata_d = frame_cnt_q;
            default:     readdata_d = {6'd0, v_cnt, 5'd0, h_cnt};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            frame_irq_q <= 1'b0;
            frame_cnt_q <= '0;
            readdata_q  <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            de_q        <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            frame_irq_q <= frame_irq_d;
            frame_cnt_q <= frame_cnt_d;
            readdata_q  <= readdata_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = frame_irq_q && ctrl_q[CTRL_IRQ_EN];
    assign hs           = hs_q;
    assign vs           = vs_q;
    assign de           = de_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing line measurements plus a reduced-
// timing instance checked every cycle against a raster-time reference model.
module tb_vga_timing_gen;
    localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 6;
    localparam int S_VA = 12, S_VF = 2, S_VS = 3, S_VB = 4;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if sm_if();
    vga_timing_gen_if d_if();

    logic        sm_irq, sm_hs, sm_vs, sm_de;
    logic [10:0] sm_px;
    logic [9:0]  sm_py;
    logic        d_irq, d_hs, d_vs, d_de;
    logic [10:0] d_px;
    logic [9:0]  d_py;

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) dut_sm (
        .clk(clk), .reset(reset), .bus(sm_if), .irq(sm_irq),
        .hs(sm_hs), .vs(sm_vs), .de(sm_de), .pix_x(sm_px), .pix_y(sm_py)
    );

    vga_timing_gen dut_def (
        .clk(clk), .reset(reset), .bus(d_if), .irq(d_irq),
        .hs(d_hs), .vs(d_vs), .de(d_de), .pix_x(d_px), .pix_y(d_py)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position is a single time index since enable.
    int unsigned m_t = 0;
    logic [3:0]  m_ctrl = '0;
    logic        m_firq = 1'b0;
    logic [31:0] m_frames = '0;
    logic [23:0] exp_vid = {2'b11, 22'd0};
    logic [31:0] exp_q[$];
    logic        chk_on = 1'b0;

    task automatic model_step();
        int h, v;
        logic was_en, fend, wr, e_de, e_hs, e_vs;
        logic [31:0] rd;
        h  = int'(m_t % S_HT);
        v  = int'(m_t / S_HT);
        wr = sm_if.chipselect && !sm_if.write_n;
        if (reset) begin
            m_t = 0; m_ctrl = '0; m_firq = 1'b0; m_frames = '0;
            exp_vid = {2'b11, 22'd0};
            rd = '0;
        end else begin
            was_en = m_ctrl[0];
            fend = was_en && h == S_HT - 1 && v == S_VT - 1;
            e_de = was_en && h < S_HA && v < S_VA;
            e_hs = (was_en && h >= S_HA + S_HF && h < S_HA + S_HF + S_HS) ? m_ctrl[1] : !m_ctrl[1];
            e_vs = (was_en && v >= S_VA + S_VF && v < S_VA + S_VF + S_VS) ? m_ctrl[2] : !m_ctrl[2];
            exp_vid = {e_hs, e_vs, e_de, e_de ? 11'(h) : 11'd0, e_de ? 10'(v) : 10'd0};
            case (sm_if.address)
                2'd0:    rd = {28'd0, m_ctrl};
                2'd1:    rd = {30'd0, v >= S_VA, m_firq};
                2'd2:    rd = m_frames;
                default: rd = {6'd0, 10'(v), 5'd0, 11'(h)};
            endcase
            if (wr && sm_if.address == 2'd1 && sm_if.writedata[0]) m_firq = 1'b0;
            if (fend) begin
                m_firq = 1'b1;
                m_frames = m_frames + 32'd1;
            end
            if (wr && sm_if.address == 2'd0) m_ctrl = sm_if.writedata[3:0];
            m_t = was_en ? (m_t + 1) % S_FRAME : 0;
        end
        exp_q.push_back(rd);
    endtask

    task automatic scoreboard_step();
        logic [31:0] rd_exp;
        if (exp_q.size() > 0) begin
            rd_exp = exp_q.pop_front();
            if (chk_on) begin
                check_eq("video", {sm_hs, sm_vs, sm_de, sm_px, sm_py}, exp_vid);
                check_eq("readdata", sm_if.readdata, rd_exp);
                check_eq("irq", sm_irq, m_firq && m_ctrl[3]);
            end
        end
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) scoreboard_step();

    task automatic sm_write(input logic [1:0] a, input logic [31:0] d);
        sm_if.address = a; sm_if.writedata = d;
        sm_if.chipselect = 1'b1; sm_if.write_n = 1'b0;
        @(negedge clk);
        sm_if.chipselect = 1'b0; sm_if.write_n = 1'b1;
    endtask

    task automatic sm_read(input logic [1:0] a, output logic [31:0] d);
        sm_if.address = a;
        @(negedge clk);
        d = sm_if.readdata;
    endtask

    task automatic random_reads(input int n);
        for (int i = 0; i < n; i++) begin
            sm_if.address = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
    endtask

    task automatic random_traffic(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                sm_write(2'd0, {28'd0, 3'($urandom_range(0, 7)), $urandom_range(0, 9) != 0});
            end else if (r < 5) begin
                sm_write(2'd1, $urandom);
            end else begin
                sm_if.address = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_sm_out"}, {sm_hs, sm_vs, sm_de, sm_px, sm_py, sm_irq}, {3'b110, 21'd0, 1'b0});
        check_eq({tag, "_sm_rd"}, sm_if.readdata, 32'd0);
    endtask

    initial begin
        int n, de_cnt, last_px, guard, hs_hi, vs_hi;
        logic [31:0] rd;

        sm_if.address = '0; sm_if.chipselect = 1'b0; sm_if.write_n = 1'b1; sm_if.writedata = '0;
        d_if.address = '0; d_if.chipselect = 1'b0; d_if.write_n = 1'b1; d_if.writedata = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check_eq("reset_def_out", {d_hs, d_vs, d_de, d_px, d_py, d_irq}, {3'b110, 21'd0, 1'b0});
        check_eq("reset_def_rd", d_if.readdata, 32'd0);
        reset = 1'b0;
        chk_on = 1'b1;

        // Default timing: enable, then measure first hsync, its width and line period.
        d_if.address = 2'd0; d_if.writedata = 32'h1; d_if.chipselect = 1'b1; d_if.write_n = 1'b0;
        @(posedge clk);
        #1;
        d_if.chipselect = 1'b0; d_if.write_n = 1'b1;
        n = 0; de_cnt = 0; last_px = 0;
        while (d_hs !== 1'b0 && n < 2000) begin
            @(posedge clk); #1; n++;
            if (d_de) begin de_cnt++; last_px = int'(d_px); end
        end
        check_eq("def_first_hs_delay", n, 657);
        check_eq("def_de_per_line", de_cnt, 640);
        check_eq("def_last_pix_x", last_px, 639);
        n = 0;
        while (d_hs !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
        check_eq("def_hs_width", n, 96);
        n = 0;
        while (d_hs !== 1'b0 && n < 2000) begin @(posedge clk); #1; n++; end
        check_eq("def_hs_gap", n, 800 - 96);
        check_eq("def_vs_idle", d_vs, 1'b1);
        @(negedge clk);

        // One frame with EN only.
        sm_write(2'd0, 32'h1);
        random_reads(S_FRAME);
        sm_read(2'd2, rd);
        check_eq("frame_cnt_one", rd, 32'd1);
        sm_read(2'd1, rd);
        check_eq("status_after_frame", rd, 32'h1);
        check_eq("irq_masked", sm_irq, 1'b0);
        sm_write(2'd0, 32'h9);
        check_eq("irq_enabled", sm_irq, 1'b1);

        // Clear landing on the frame-end edge loses; the next one wins.
        guard = 0;
        while (!(m_ctrl[0] && m_t == S_FRAME - 1) && guard < 2 * S_FRAME) begin
            @(negedge clk); guard++;
        end
        check_eq("reach_frame_end", guard < 2 * S_FRAME, 1'b1);
        sm_write(2'd1, 32'h1);
        check_eq("irq_set_wins", sm_irq, 1'b1);
        sm_write(2'd1, 32'h1);
        check_eq("irq_cleared", sm_irq, 1'b0);

        random_traffic(2500);

        // Active-high syncs over one whole frame window.
        sm_write(2'd0, 32'h7);
        @(negedge clk);
        hs_hi = 0; vs_hi = 0;
        for (int i = 0; i < S_FRAME; i++) begin
            @(negedge clk);
            if (sm_hs) hs_hi++;
            if (sm_vs) vs_hi++;
        end
        check_eq("hs_high_per_frame", hs_hi, S_VT * S_HS);
        check_eq("vs_high_per_frame", vs_hi, S_HT * S_VS);

        // Clear EN mid-line.
        guard = 0;
        while (!(m_t % S_HT == 10) && guard < 2 * S_HT) begin @(negedge clk); guard++; end
        check_eq("reach_mid_line", guard < 2 * S_HT, 1'b1);
        sm_write(2'd0, 32'h6);
        @(negedge clk);
        check_eq("disable_outputs", {sm_hs, sm_vs, sm_de, sm_px, sm_py}, 24'd0);
        sm_read(2'd3, rd);
        check_eq("disable_pos", rd, 32'd0);

        // Reset mid-frame with a colliding CTRL write.
        sm_write(2'd0, 32'h1);
        random_reads(300);
        reset = 1'b1;
        sm_if.address = 2'd0; sm_if.writedata = 32'hF;
        sm_if.chipselect = 1'b1; sm_if.write_n = 1'b0;
        @(negedge clk);
        sm_if.chipselect = 1'b0; sm_if.write_n = 1'b1;
        check_idle_outputs("midreset");
        reset = 1'b0;
        sm_read(2'd2, rd);
        check_eq("midreset_frame_cnt", rd, 32'd0);
        sm_read(2'd0, rd);
        check_eq("midreset_ctrl", rd, 32'd0);
        random_reads(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 Parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Ports, in this order:
- clk  in  1  pixel clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- address  in  2  Avalon-MM slave word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  frame interrupt, level.
- hs  out  1  horizontal sync; polarity per CTRL.
- vs  out  1  vertical sync; polarity per CTRL.
- de  out  1  display enable, high in the visible region.
- pix_x  out  11  current visible column.
- pix_y  out  10  current visible row.

Function
REQ-010 Register map:
- 0 CTRL (RW): bit0 EN, bit1 HPOL, bit2 VPOL, bit3 IRQ_EN. Polarity bit 0 means the pulse is active-low.
- 1 STATUS: bit0 FRAME_IRQ (sticky; write 1 to clear), bit1 VBLANK (read-only).
- 2 FRAME_CNT (RO): 32-bit count of completed frames.
- 3 POS (RO): {v_cnt[25:16], 5'b0, h_cnt[10:0]}.
REQ-011 Writes take effect when chipselect && !write_n, on the rising clk edge.
REQ-012 readdata is updated every cycle from address, giving 1-cycle read latency. chipselect is not required for reads, and reads have no side effects.
REQ-013 While EN=1, h_cnt counts 0..HT-1, with HT = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default), and wraps to 0.
REQ-014 v_cnt increments when h_cnt wraps, counts 0..VT-1 (VT = 525 by default), and wraps to 0.
REQ-015 While EN=0, h_cnt and v_cnt are held at 0 and hs/vs/de are driven inactive. The next cycle after EN goes 1 begins at h_cnt=0, v_cnt=0.
REQ-016 The sync pulses are active exactly over these ranges; all outputs are registered with 1 cycle of latency from the counters:
- hs: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751] by default.
- vs: v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491] by default.
REQ-017 de = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE), using the same 1-cycle latency. When de=1, pix_x=h_cnt and pix_y=v_cnt; when de=0, both are 0.
REQ-018 VBLANK = (v_cnt>=V_ACTIVE), taken from the current counter.
REQ-019 Frame end is h_cnt=HT-1 && v_cnt=VT-1 with EN=1. On frame end:
- FRAME_CNT increments, wrapping from 0xFFFFFFFF to 0.
- FRAME_IRQ sets.
REQ-020 If a FRAME_IRQ clear write and a frame end fall in the same cycle, the set wins.
REQ-021 irq = FRAME_IRQ && IRQ_EN, driven combinationally from the registers.
REQ-022 Changing HPOL/VPOL mid-frame takes effect on the next output register update and does not disturb the counters.
REQ-023 Clearing EN mid-frame resets the counters on the next edge. FRAME_CNT and FRAME_IRQ are retained.

Reset
REQ-024 reset=1 at a clk edge clears all state: CTRL=0, FRAME_IRQ=0, FRAME_CNT=0, h_cnt=0, v_cnt=0, readdata=0.
REQ-025 During and after reset: hs=1, vs=1 (inactive low-polarity), de=0, pix_x=0, pix_y=0, irq=0.
REQ-026 Reset has priority over any simultaneous write.

Structure
REQ-027 A shared package vga_pkg holds:
- the default timing constants;
- register address constants (ADDR_CTRL=0, ADDR_STATUS=1, ADDR_FRAME=2, ADDR_POS=3);
- the CTRL bit index constants.
REQ-028 One sub-module vga_axis_counter (counter, wrap flag, sync and active decode) is instantiated twice, once for horizontal and once for vertical.

Verification
REQ-029 Reset, then write CTRL=0x1 -> first hs low exactly 657 cycles after EN is registered; hs pulse 96 cycles wide; line period 800 cycles.
REQ-030 EN=1 with defaults, run one frame -> vs low for 1600 cycles starting at line 490; de high for 640 cycles per line on lines 0..479 only; pix_x steps 0..639.
REQ-031 After 420000 cycles (one frame) -> FRAME_CNT reads 1; STATUS bit0=1; irq=1 only if CTRL=0x9.
REQ-032 Write STATUS=0x1 in the same cycle as a frame end -> FRAME_IRQ stays 1; a write one cycle later clears it.
REQ-033 CTRL=0x7 -> hs and vs become active-high pulses with the same timing; clearing EN mid-line -> hs=0, vs=0, de=0 on the next cycle, and POS reads 0.
REQ-034 Assert reset mid-frame with EN=1 -> all outputs take their REQ-025 values on the next edge and FRAME_CNT reads 0.
